// File: rtl/result_checker_pkg.sv
// Shared types for the X9 result checker: FSM states, table entry layout
// and a small clamp helper.
package x9_chk_pkg;

  localparam int unsigned CHK_DW = 8;
  localparam int unsigned CHK_AW = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } chk_state_t;

  typedef struct packed {
    logic [CHK_AW-1:0] addr;
    logic [CHK_DW-1:0] data;
  } chk_entry_t;

  function automatic int unsigned chk_clamp(int unsigned v, int unsigned hi);
    return (v > hi) ? hi : v;
  endfunction

endpackage

// File: rtl/result_checker_if.sv
// Bundle of table-load, trigger, memory read port and status signals.
// master: the environment (processor, loader, data memory); slave: the checker.
interface result_checker_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned N_CHK = 16
);
  localparam int unsigned IW = (N_CHK > 1) ? $clog2(N_CHK) : 1;
  localparam int unsigned CW = $clog2(N_CHK + 1);

  logic          done;
  logic          ld_en;
  logic [IW-1:0] ld_idx;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [CW-1:0] num_chk;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          check_done;
  logic          pass;
  logic [CW-1:0] err_count;
  logic [IW-1:0] first_err_idx;
  logic [DW-1:0] first_err_exp;
  logic [DW-1:0] first_err_got;

  modport master (
    output done, ld_en, ld_idx, ld_addr, ld_data, num_chk, rd_data,
    input  rd_addr, busy, check_done, pass, err_count,
           first_err_idx, first_err_exp, first_err_got
  );

  modport slave (
    input  done, ld_en, ld_idx, ld_addr, ld_data, num_chk, rd_data,
    output rd_addr, busy, check_done, pass, err_count,
           first_err_idx, first_err_exp, first_err_got
  );

endinterface

// File: rtl/result_checker_chk_table.sv
// Expected-value table: N_CHK (addr, data) registers, one write port and two
// independent combinational read ports (address for issue, data for compare).
// Contents are intentionally not reset.
module chk_table #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned N_CHK = 16,
  parameter int unsigned IW    = (N_CHK > 1) ? $clog2(N_CHK) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [IW-1:0] addr_idx_i,
  output logic [AW-1:0] addr_o,
  input  logic [IW-1:0] data_idx_i,
  output logic [DW-1:0] data_o
);

  logic [AW-1:0] addr_q [N_CHK];
  logic [DW-1:0] data_q [N_CHK];

  // Table write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      addr_q[wr_idx_i] <= wr_addr_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Combinational read ports.
  always_comb begin
    addr_o = addr_q[addr_idx_i];
    data_o = data_q[data_idx_i];
  end

endmodule

// File: rtl/result_checker.sv
// Self-check engine: on a rising edge of done, walks the expected table,
// reads data memory and reports pass/fail, error count and first mismatch.
module result_checker
  import x9_chk_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 8,
  parameter int unsigned N_CHK  = 16,
  parameter int unsigned RD_LAT = 0
) (
  input logic       clk,
  input logic       reset,
  result_checker_if.slave bus
);

  localparam int unsigned IW = (N_CHK > 1) ? $clog2(N_CHK) : 1;
  localparam int unsigned CW = $clog2(N_CHK + 1);

  chk_state_t    state_q, state_d;
  logic          done_q;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] issue_q, issue_d;
  logic          vld_q, vld_d;
  logic [IW-1:0] cmp_idx_q, cmp_idx_d;
  logic [CW-1:0] err_q, err_d;
  logic          pass_q, pass_d;
  logic [IW-1:0] fidx_q, fidx_d;
  logic [DW-1:0] fexp_q, fexp_d;
  logic [DW-1:0] fgot_q, fgot_d;

  logic          trig;
  logic          issuing;
  logic          last_cmp;
  logic          cmp_en;
  logic [IW-1:0] data_idx;
  logic [AW-1:0] tab_addr;
  logic [DW-1:0] tab_data;
  logic [CW-1:0] n_clamp;

  chk_table #(
    .DW    (DW),
    .AW    (AW),
    .N_CHK (N_CHK),
    .IW    (IW)
  ) u_table (
    .clk_i      (clk),
    .we_i       (bus.ld_en && (state_q == IDLE)),
    .wr_idx_i   (bus.ld_idx),
    .wr_addr_i  (bus.ld_addr),
    .wr_data_i  (bus.ld_data),
    .addr_idx_i (issue_q[IW-1:0]),
    .addr_o     (tab_addr),
    .data_idx_i (data_idx),
    .data_o     (tab_data)
  );

  // Trigger detection and issue/compare control. With registered memory the
  // compare trails the issue by one cycle, so RUN takes one extra cycle to
  // drain the last read.
  always_comb begin
    trig     = bus.done && !done_q && (state_q == IDLE);
    n_clamp  = CW'(chk_clamp(32'(bus.num_chk), N_CHK));
    if (RD_LAT == 0) begin
      issuing  = (state_q == RUN);
      cmp_en   = (state_q == RUN);
      data_idx = issue_q[IW-1:0];
      last_cmp = (issue_q == n_q - CW'(1));
    end else begin
      issuing  = (state_q == RUN) && (issue_q < n_q);
      cmp_en   = (state_q == RUN) && vld_q;
      data_idx = cmp_idx_q;
      last_cmp = (issue_q == n_q);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (trig) state_d = (n_clamp == '0) ? FIN : RUN;
      RUN:  if (last_cmp) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: run setup, index stepping, mismatch accounting.
  always_comb begin
    n_d       = n_q;
    issue_d   = issue_q;
    vld_d     = vld_q;
    cmp_idx_d = cmp_idx_q;
    err_d     = err_q;
    pass_d    = pass_q;
    fidx_d    = fidx_q;
    fexp_d    = fexp_q;
    fgot_d    = fgot_q;
    if (trig) begin
      n_d     = n_clamp;
      issue_d = '0;
      vld_d   = 1'b0;
      err_d   = '0;
      pass_d  = 1'b0;
      fidx_d  = '0;
      fexp_d  = '0;
      fgot_d  = '0;
    end
    if (state_q == RUN) begin
      issue_d   = issue_q + CW'(1);
      vld_d     = issuing;
      cmp_idx_d = issue_q[IW-1:0];
      if (cmp_en && (bus.rd_data != tab_data)) begin
        err_d = err_q + CW'(1);
        if (err_q == '0) begin
          fidx_d = data_idx;
          fexp_d = tab_data;
          fgot_d = bus.rd_data;
        end
      end
    end
    if ((state_d == FIN) && (state_q != FIN)) pass_d = (err_d == '0);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q    <= 1'b0;
      n_q       <= '0;
      issue_q   <= '0;
      vld_q     <= 1'b0;
      cmp_idx_q <= '0;
      err_q     <= '0;
      pass_q    <= 1'b0;
      fidx_q    <= '0;
      fexp_q    <= '0;
      fgot_q    <= '0;
    end else begin
      done_q    <= bus.done;
      n_q       <= n_d;
      issue_q   <= issue_d;
      vld_q     <= vld_d;
      cmp_idx_q <= cmp_idx_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      fidx_q    <= fidx_d;
      fexp_q    <= fexp_d;
      fgot_q    <= fgot_d;
    end
  end

  // Outputs: read address only while issuing, status from registers.
  always_comb begin
    bus.rd_addr       = issuing ? tab_addr : '0;
    bus.busy          = (state_q != IDLE);
    bus.check_done    = (state_q == FIN);
    bus.pass          = pass_q;
    bus.err_count     = err_q;
    bus.first_err_idx = fidx_q;
    bus.first_err_exp = fexp_q;
    bus.first_err_got = fgot_q;
  end

endmodule
